// File: rtl/pll_reset_sequencer_pkg.sv
// Shared definitions for the board-level PLL reset sequencer.
//  - S_PLLRST..S_FAIL : 3-bit state encodings
//  - seq_out_t        : the four 1-bit sequencer outputs as one struct
//  - decode_state()   : Moore output decode of a state code
package pll_reset_sequencer_pkg;

  localparam logic [2:0] S_PLLRST   = 3'd0;
  localparam logic [2:0] S_WAITLOCK = 3'd1;
  localparam logic [2:0] S_SETTLE   = 3'd2;
  localparam logic [2:0] S_RUN      = 3'd3;
  localparam logic [2:0] S_FAIL     = 3'd4;

  typedef struct packed {
    logic pll_areset;
    logic soc_reset;
    logic seq_ready;
    logic seq_fail;
  } seq_out_t;

  // Unknown codes decode like PLLRST so that the PLL and SoC stay in reset.
  function automatic seq_out_t decode_state(input logic [2:0] s);
    seq_out_t o;
    o = '{pll_areset: 1'b1, soc_reset: 1'b1, seq_ready: 1'b0, seq_fail: 1'b0};
    case (s)
      S_WAITLOCK, S_SETTLE: o.pll_areset = 1'b0;
      S_RUN: begin
        o.pll_areset = 1'b0;
        o.soc_reset  = 1'b0;
        o.seq_ready  = 1'b1;
      end
      S_FAIL:  o.seq_fail = 1'b1;
      default: ;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// User button synchroniser and debouncer.
//  clk     in  board clock (CLK12M)
//  reset   in  synchronous, active-high
//  btn_n   in  raw button, active-low, asynchronous to clk
//  press   out 1-cycle pulse when the debounced button goes from released to pressed
// The debounced level only follows the synchronised input after it has differed
// for DEBOUNCE_CYCLES consecutive cycles; any agreeing cycle restarts the count.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 120000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_n,
  output logic press
);

  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DW-1:0] CNT_LAST = DW'(DEBOUNCE_CYCLES - 1);

  logic          btn_m;
  logic          btn_s;
  logic          btn_stable;
  logic [DW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      btn_m      <= 1'b1;
      btn_s      <= 1'b1;
      btn_stable <= 1'b1;
      cnt        <= '0;
      press      <= 1'b0;
    end else begin
      btn_m <= btn_n;
      btn_s <= btn_m;
      press <= 1'b0;
      if (btn_s == btn_stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        btn_stable <= btn_s;
        cnt        <= '0;
        // Only a fall of the stable level (button pressed) is an event.
        press      <= btn_stable & ~btn_s;
      end else begin
        cnt <= cnt + DW'(1);
      end
    end
  end

endmodule

// File: rtl/pll_reset_sequencer.sv
// Board-level reset/PLL controller running on the raw board clock.
// Pulses the PLL areset, waits for lock with a timeout and bounded retries,
// requires lock to hold for a settle period, then releases soc_reset.
//  clk          in   board clock (CLK12M)
//  reset        in   synchronous, active-high
//  btn_n        in   raw user button, active-low, asynchronous
//  pll_locked   in   PLL lock, asynchronous
//  pll_areset   out  PLL reset, active-high
//  soc_reset    out  SoC reset request, active-high
//  seq_ready    out  1 while in RUN
//  seq_fail     out  1 while in FAIL
//  retry_count  out  lock timeouts seen in the current sequence
module pll_reset_sequencer
  import pll_reset_sequencer_pkg::*;
#(
  parameter int PLL_RST_CYCLES  = 16,
  parameter int LOCK_TIMEOUT    = 12000,
  parameter int SETTLE_CYCLES   = 1200,
  parameter int DEBOUNCE_CYCLES = 120000,
  parameter int MAX_RETRY       = 3,
  parameter int CNT_W           = 17,
  parameter int RETRY_W         = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               btn_n,
  input  logic               pll_locked,
  output logic               pll_areset,
  output logic               soc_reset,
  output logic               seq_ready,
  output logic               seq_fail,
  output logic [RETRY_W-1:0] retry_count
);

  localparam logic [CNT_W-1:0]   T_RST    = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]   T_LOCK   = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   T_SETTLE = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] R_MAX    = RETRY_W'(MAX_RETRY);

  logic               press;
  logic               lock_m;
  logic               lock_s;
  logic [2:0]         state;
  logic [2:0]         state_nxt;
  logic [CNT_W-1:0]   timer;
  logic [CNT_W-1:0]   timer_nxt;
  logic [RETRY_W-1:0] retry_nxt;
  seq_out_t           out_nxt;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
    .clk   (clk),
    .reset (reset),
    .btn_n (btn_n),
    .press (press)
  );

  // Priority: press > lock loss > timer expiry (reset handled in the register).
  always_comb begin
    state_nxt = state;
    retry_nxt = retry_count;
    timer_nxt = (timer == '1) ? timer : timer + CNT_W'(1);
    if (press) begin
      state_nxt = S_PLLRST;
      retry_nxt = '0;
    end else begin
      case (state)
        S_PLLRST: if (timer == T_RST) state_nxt = S_WAITLOCK;
        S_WAITLOCK: begin
          if (lock_s) begin
            state_nxt = S_SETTLE;
          end else if (timer == T_LOCK) begin
            if (retry_count == R_MAX) begin
              state_nxt = S_FAIL;
            end else begin
              retry_nxt = retry_count + RETRY_W'(1);
              state_nxt = S_PLLRST;
            end
          end
        end
        S_SETTLE: begin
          if (!lock_s) begin
            state_nxt = S_PLLRST;
          end else if (timer == T_SETTLE) begin
            state_nxt = S_RUN;
            retry_nxt = '0;
          end
        end
        S_RUN:   if (!lock_s) state_nxt = S_PLLRST;
        S_FAIL:  ;
        default: state_nxt = S_PLLRST;
      endcase
    end
    // A press while already in PLLRST restarts the areset pulse too.
    if (press || (state_nxt != state)) timer_nxt = '0;
    out_nxt = decode_state(state_nxt);
  end

  // Outputs are decoded from the next state so they change on the same edge
  // as the state register and come straight from flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      lock_m      <= 1'b0;
      lock_s      <= 1'b0;
      state       <= S_PLLRST;
      timer       <= '0;
      retry_count <= '0;
      pll_areset  <= 1'b1;
      soc_reset   <= 1'b1;
      seq_ready   <= 1'b0;
      seq_fail    <= 1'b0;
    end else begin
      lock_m      <= pll_locked;
      lock_s      <= lock_m;
      state       <= state_nxt;
      timer       <= timer_nxt;
      retry_count <= retry_nxt;
      pll_areset  <= out_nxt.pll_areset;
      soc_reset   <= out_nxt.soc_reset;
      seq_ready   <= out_nxt.seq_ready;
      seq_fail    <= out_nxt.seq_fail;
    end
  end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed-plus-random bench for pll_reset_sequencer. Expected outputs come from
// timeline arithmetic: k counts clock edges since the sequence (re)entered PLL
// reset, and each phase boundary is a sum of the cycle parameters.
module tb_pll_reset_sequencer;

  localparam int P_RST  = 4;
  localparam int P_LOCK = 20;
  localparam int P_SET  = 8;
  localparam int P_DEB  = 5;
  localparam int P_MAXR = 2;
  localparam int BOOT   = P_RST + 1 + P_SET;   // edges from PLL reset entry to RUN
  localparam int PERIOD = P_RST + P_LOCK;      // one failed lock attempt
  localparam int PRESS_LAT = 2 + P_DEB;        // sync + debounce + press register

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_n = 1'b1;
  logic       pll_locked = 1'b0;
  logic       pll_areset;
  logic       soc_reset;
  logic       seq_ready;
  logic       seq_fail;
  logic [1:0] retry_count;

  int n_vec = 0;
  int n_err = 0;

  pll_reset_sequencer #(
    .PLL_RST_CYCLES (P_RST),
    .LOCK_TIMEOUT   (P_LOCK),
    .SETTLE_CYCLES  (P_SET),
    .DEBOUNCE_CYCLES(P_DEB),
    .MAX_RETRY      (P_MAXR),
    .CNT_W          (17),
    .RETRY_W        (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_n      (btn_n),
    .pll_locked (pll_locked),
    .pll_areset (pll_areset),
    .soc_reset  (soc_reset),
    .seq_ready  (seq_ready),
    .seq_fail   (seq_fail),
    .retry_count(retry_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input bit a, input bit s, input bit r,
                         input bit f, input int rc);
    chk({tag, ".pll_areset"}, 32'(pll_areset), 32'(a));
    chk({tag, ".soc_reset"}, 32'(soc_reset), 32'(s));
    chk({tag, ".seq_ready"}, 32'(seq_ready), 32'(r));
    chk({tag, ".seq_fail"}, 32'(seq_fail), 32'(f));
    chk({tag, ".retry_count"}, 32'(retry_count), 32'(rc));
  endtask

  // Hold reset for 'hold' edges; returns just after the last reset edge (k=0).
  task automatic do_reset(input int hold);
    reset = 1'b1;
    repeat (hold) begin
      tick();
      chk_all("reset", 1, 1, 0, 0, 0);
    end
    reset = 1'b0;
  endtask

  // Called at k=0 (just after PLL reset entry) with lock high at the pin.
  task automatic boot_run(input string tag, input int n, input int rc0);
    for (int k = 0; k < n; k++) begin
      if (k > 0) tick();
      chk_all($sformatf("%s k%0d", tag, k), k < P_RST, k < BOOT, k >= BOOT, 0,
              (k < BOOT) ? rc0 : 0);
    end
  endtask

  task automatic run_hold(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      chk_all($sformatf("%s c%0d", tag, i), 0, 0, 1, 0, 0);
    end
  endtask

  // Low for h (5..7) edges; the press reaches the FSM PRESS_LAT edges after the
  // first low sample. Returns at the PLL reset entry edge (k=0).
  task automatic press_btn(input string tag, input int h, input bit a, input bit s,
                           input bit r, input bit f, input int rc);
    btn_n = 1'b0;
    for (int i = 0; i < PRESS_LAT; i++) begin
      tick();
      chk_all($sformatf("%s pre%0d", tag, i), a, s, r, f, rc);
      if (i + 1 == h) btn_n = 1'b1;
    end
    tick();
  endtask

  // Lock low at the pin for d (1..3) edges while in RUN; RUN holds for two
  // edges and PLL reset is entered on the third. Returns at k=0.
  task automatic lock_drop(input string tag, input int d);
    pll_locked = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk_all($sformatf("%s pre%0d", tag, i), 0, 0, 1, 0, 0);
      if (i + 1 == d) pll_locked = 1'b1;
    end
    tick();
    if (d == 3) pll_locked = 1'b1;
  endtask

  // One lock timeout, then lock rises during the second PLL reset pulse.
  // The second attempt starts at k=PERIOD, so RUN is reached at PERIOD+BOOT.
  // Stops after observing edge k_stop.
  task automatic retry_then_lock(input string tag, input int k_stop);
    pll_locked = 1'b0;
    do_reset(2);
    for (int k = 1; k <= k_stop; k++) begin
      tick();
      if (k <= PERIOD)
        chk_all($sformatf("%s k%0d", tag, k), (k % PERIOD) < P_RST, 1, 0, 0, k / PERIOD);
      else
        chk_all($sformatf("%s k%0d", tag, k), k < PERIOD + P_RST, k < PERIOD + BOOT,
                k >= PERIOD + BOOT, 0, (k < PERIOD + BOOT) ? 1 : 0);
      if (k == PERIOD) pll_locked = 1'b1;
    end
  endtask

  initial begin
    int iv;
    int cnt;
    int ks;

    // 1: nominal boot with lock already high
    pll_locked = 1'b1;
    do_reset($urandom_range(2, 4));
    boot_run("boot", BOOT + 1 + $urandom_range(0, 5), 0);

    // 4: short lock losses in RUN, each followed by a full re-sequence
    for (int n = 0; n < 3; n++) begin
      lock_drop($sformatf("drop%0d", n), (n == 0) ? 1 : $urandom_range(1, 3));
      boot_run($sformatf("reboot%0d", n), BOOT + 3, 0);
    end

    // 5: button chatter shorter than the debounce window never yields a press
    for (int pass = 0; pass < 2; pass++) begin
      iv = (pass == 0) ? 3 : $urandom_range(1, P_DEB - 1);
      cnt = 0;
      for (int i = 0; i < 30; i++) begin
        tick();
        chk_all($sformatf("chatter%0d c%0d", pass, i), 0, 0, 1, 0, 0);
        cnt++;
        if (cnt == iv) begin
          btn_n = ~btn_n;
          cnt = 0;
          if (pass == 1) iv = $urandom_range(1, P_DEB - 1);
        end
      end
      btn_n = 1'b1;
      run_hold($sformatf("chatter%0d tail", pass), 8);
    end

    // user reboot from RUN
    press_btn("run_press", $urandom_range(P_DEB, PRESS_LAT), 0, 0, 1, 0, 0);
    boot_run("run_press boot", BOOT + 10, 0);

    // 2: lock never comes: MAX_RETRY+1 attempts, then FAIL
    pll_locked = 1'b0;
    do_reset(2);
    for (int k = 1; k < (P_MAXR + 1) * PERIOD + 4; k++) begin
      tick();
      if (k < (P_MAXR + 1) * PERIOD)
        chk_all($sformatf("nolock k%0d", k), (k % PERIOD) < P_RST, 1, 0, 0, k / PERIOD);
      else
        chk_all($sformatf("fail k%0d", k), 1, 1, 0, 1, P_MAXR);
    end

    // 3: press from FAIL with lock now present; release must not re-trigger
    pll_locked = 1'b1;
    press_btn("fail_press", 7, 1, 1, 0, 1, P_MAXR);
    boot_run("fail_press boot", BOOT + 12, 0);

    // one timeout then lock: retry count visible until RUN clears it
    retry_then_lock("retry", PERIOD + BOOT + 3);

    // 6: reset asserted while in SETTLE
    ks = $urandom_range(PERIOD + P_RST + 1, PERIOD + BOOT - 2);
    retry_then_lock("settle", ks);
    reset = 1'b1;
    tick();
    chk_all("settle_reset", 1, 1, 0, 0, 0);
    do_reset($urandom_range(1, 3));
    boot_run("after_reset", BOOT + 2, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
